// File: rtl/ctrl_fsm_if.sv
// ctrl_fsm_if: bundle of the control unit's bus and datapath-control signals.
//   Memory side : instr, mem_ready (in to controller), mem_req, mem_we (out)
//   ALU side    : zero, neg (in), alu_op, alu_src_b (out)
//   Datapath    : ir_we, pc_inc, pc_load, reg_we, wb_sel (out)
//   Status      : halted, trap, state (out)
// master = the controller, slave = datapath/memory side.
interface ctrl_fsm_if;
    logic [15:0] instr;
    logic        mem_ready;
    logic        zero;
    logic        neg;
    logic [3:0]  alu_op;
    logic [1:0]  alu_src_b;
    logic        ir_we;
    logic        pc_inc;
    logic        pc_load;
    logic        reg_we;
    logic        wb_sel;
    logic        mem_req;
    logic        mem_we;
    logic        halted;
    logic        trap;
    logic [2:0]  state;

    modport master (
        input  instr, mem_ready, zero, neg,
        output alu_op, alu_src_b, ir_we, pc_inc, pc_load, reg_we, wb_sel,
               mem_req, mem_we, halted, trap, state
    );

    modport slave (
        output instr, mem_ready, zero, neg,
        input  alu_op, alu_src_b, ir_we, pc_inc, pc_load, reg_we, wb_sel,
               mem_req, mem_we, halted, trap, state
    );
endinterface

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle control unit of the 16-bit core.
// Sequences FETCH/DECODE/EXEC/MEM/WB over a ready-handshaked memory bus and
// drives ALU opcode, operand select, datapath write enables and mux selects.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - ctrl_fsm_if.master (instr/mem_ready/zero/neg in, all controls out)
// Outputs are combinational from the state register, the latched opcode and
// mem_ready; write strobes are additionally gated by rst_n so a reset
// asserted mid-transaction silences the bus in the same cycle.
module ctrl_fsm (
    input  logic          clk,
    input  logic          rst_n,
    ctrl_fsm_if.master    bus
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5,
        TRAP   = 3'd6
    } state_t;

    localparam logic [3:0] OP_LUI  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LW   = 4'h7;
    localparam logic [3:0] OP_SW   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_BLT  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t     state_r;
    logic [3:0] op_r;

    // ALU opcode for the latched instruction (EXEC and the held WB value).
    function automatic logic [3:0] alu_op_of(input logic [3:0] op);
        logic [3:0] res;
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4: res = op;
            OP_LUI:                       res = 4'd5;
            OP_BEQ, OP_BLT:               res = 4'd1;
            default:                      res = 4'd0;
        endcase
        return res;
    endfunction

    // ALU B operand select for the latched instruction.
    function automatic logic [1:0] src_b_of(input logic [3:0] op);
        logic [1:0] res;
        case (op)
            OP_LUI:                res = 2'd2;
            OP_ADDI, OP_LW, OP_SW: res = 2'd1;
            default:               res = 2'd0;
        endcase
        return res;
    endfunction

    logic ir_we_s, pc_inc_s, pc_load_s, reg_we_s, mem_req_s, mem_we_s;
    logic wb_sel_s, halted_s, trap_s;
    logic [3:0] alu_op_s;
    logic [1:0] alu_src_b_s;

    // State register and opcode latch; the latch loads only on the fetch handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= FETCH;
            op_r    <= 4'd0;
        end else begin
            case (state_r)
                FETCH: begin
                    if (bus.mem_ready) begin
                        op_r    <= bus.instr[15:12];
                        state_r <= DECODE;
                    end else begin
                        state_r <= FETCH;
                    end
                end
                DECODE: begin
                    case (op_r)
                        OP_JMP:             state_r <= FETCH;
                        OP_HALT:            state_r <= HALT;
                        4'hC, 4'hD, 4'hE:   state_r <= TRAP;
                        default:            state_r <= EXEC;
                    endcase
                end
                EXEC: begin
                    if (op_r == OP_BEQ || op_r == OP_BLT) begin
                        state_r <= FETCH;
                    end else if (op_r == OP_LW || op_r == OP_SW) begin
                        state_r <= MEM;
                    end else begin
                        state_r <= WB;
                    end
                end
                MEM: begin
                    if (bus.mem_ready) begin
                        state_r <= (op_r == OP_SW) ? FETCH : WB;
                    end else begin
                        state_r <= MEM;
                    end
                end
                WB:      state_r <= FETCH;
                HALT:    state_r <= HALT;
                TRAP:    state_r <= TRAP;
                default: state_r <= FETCH;
            endcase
        end
    end

    // Output decode from state, latched opcode and mem_ready.
    always_comb begin
        ir_we_s     = 1'b0;
        pc_inc_s    = 1'b0;
        pc_load_s   = 1'b0;
        reg_we_s    = 1'b0;
        mem_req_s   = 1'b0;
        mem_we_s    = 1'b0;
        wb_sel_s    = 1'b0;
        halted_s    = 1'b0;
        trap_s      = 1'b0;
        alu_op_s    = 4'd0;
        alu_src_b_s = 2'd0;
        case (state_r)
            FETCH: begin
                mem_req_s = 1'b1;
                ir_we_s   = bus.mem_ready;
                pc_inc_s  = bus.mem_ready;
            end
            DECODE: begin
                pc_load_s = (op_r == OP_JMP);
            end
            EXEC: begin
                alu_op_s    = alu_op_of(op_r);
                alu_src_b_s = src_b_of(op_r);
                if (op_r == OP_BEQ) begin
                    pc_load_s = bus.zero;
                end else if (op_r == OP_BLT) begin
                    pc_load_s = bus.neg;
                end else begin
                    pc_load_s = 1'b0;
                end
            end
            MEM: begin
                // Address (rs + imm6) kept on the ALU for the whole wait.
                mem_req_s   = 1'b1;
                mem_we_s    = (op_r == OP_SW);
                alu_op_s    = 4'd0;
                alu_src_b_s = 2'd1;
            end
            WB: begin
                reg_we_s    = 1'b1;
                wb_sel_s    = (op_r == OP_LW);
                alu_op_s    = alu_op_of(op_r);
                alu_src_b_s = src_b_of(op_r);
            end
            HALT:    halted_s = 1'b1;
            TRAP:    trap_s   = 1'b1;
            default: ;
        endcase
    end

    assign bus.ir_we     = ir_we_s   & rst_n;
    assign bus.pc_inc    = pc_inc_s  & rst_n;
    assign bus.pc_load   = pc_load_s & rst_n;
    assign bus.reg_we    = reg_we_s  & rst_n;
    assign bus.mem_req   = mem_req_s & rst_n;
    assign bus.mem_we    = mem_we_s  & rst_n;
    assign bus.wb_sel    = wb_sel_s;
    assign bus.halted    = halted_s;
    assign bus.trap      = trap_s;
    assign bus.alu_op    = alu_op_s;
    assign bus.alu_src_b = alu_src_b_s;
    assign bus.state     = state_r;

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm: self-checking bench for ctrl_fsm. Each clock cycle is one
// record {inputs, expected outputs}; records come from a hand-written table,
// from an instruction-level trace builder that expands an instruction into
// its cycle list, and from short hand-written reset/terminal sequences.
module tb_ctrl_fsm;

    logic clk;
    logic rst_n;
    ctrl_fsm_if bus();

    ctrl_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected strobe bits: {ir_we,pc_inc,pc_load,reg_we,wb_sel,mem_req,mem_we,halted,trap}
    localparam logic [8:0] S_IR  = 9'h100;
    localparam logic [8:0] S_PCI = 9'h080;
    localparam logic [8:0] S_PCL = 9'h040;
    localparam logic [8:0] S_RWE = 9'h020;
    localparam logic [8:0] S_WBS = 9'h010;
    localparam logic [8:0] S_REQ = 9'h008;
    localparam logic [8:0] S_WE  = 9'h004;
    localparam logic [8:0] S_HLT = 9'h002;
    localparam logic [8:0] S_TRP = 9'h001;

    typedef struct {
        logic [63:0] nm;
        logic        rst;
        logic [15:0] ins;
        logic        rdy;
        logic        z;
        logic        n;
        logic        chk;
        logic [17:0] exp;
    } cyc_t;

    cyc_t q[$];
    cyc_t add_tab[4];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic done_r  = 1'b0;

    function automatic logic [17:0] ex(input logic [2:0] st, input logic [3:0] aop,
                                       input logic [1:0] sb, input logic [8:0] stb);
        return {st, aop, sb, stb};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic cyc_t mk(input logic [63:0] nm, input logic r, input logic [15:0] ins,
                                input logic rdy, input logic z, input logic n,
                                input logic chk, input logic [17:0] e);
        cyc_t c;
        c.nm = nm; c.rst = r; c.ins = ins; c.rdy = rdy;
        c.z = z; c.n = n; c.chk = chk; c.exp = e;
        return c;
    endfunction

    task automatic push(input logic [63:0] nm, input logic r, input logic [15:0] ins,
                        input logic rdy, input logic z, input logic n,
                        input logic chk, input logic [17:0] e);
        q.push_back(mk(nm, r, ins, rdy, z, n, chk, e));
    endtask

    // Expand one instruction into its per-cycle expectations: fw fetch waits,
    // mw memory waits, flag = value of the flag the branch tests in EXEC.
    // Non-handshake cycles get random instr/mem_ready/flags, which must be ignored.
    task automatic gen(input logic [63:0] nm, input logic [15:0] ins, input int fw,
                       input int mw, input logic flag);
        logic [3:0] op;
        logic [3:0] aop;
        logic [1:0] sb;
        logic       br, is_mem, wb, z, n;
        op     = ins[15:12];
        aop    = (op <= 4'd4) ? op : (op == 4'd5) ? 4'd5 : (op == 4'd9 || op == 4'd10) ? 4'd1 : 4'd0;
        sb     = (op == 4'd5) ? 2'd2 : (op >= 4'd6 && op <= 4'd8) ? 2'd1 : 2'd0;
        br     = (op == 4'd9 || op == 4'd10);
        is_mem = (op == 4'd7 || op == 4'd8);
        wb     = (op <= 4'd7);
        for (int i = 0; i < fw; i++)
            push(nm, 1'b1, 16'($urandom), 1'b0, rb(), rb(), 1'b1, ex(3'd0, 4'd0, 2'd0, S_REQ));
        push(nm, 1'b1, ins, 1'b1, rb(), rb(), 1'b1, ex(3'd0, 4'd0, 2'd0, S_IR | S_PCI | S_REQ));
        push(nm, 1'b1, 16'($urandom), rb(), rb(), rb(), 1'b1,
             ex(3'd1, 4'd0, 2'd0, (op == 4'hB) ? S_PCL : 9'h000));
        if (op < 4'hB) begin
            z = (op == 4'd9)  ? flag : rb();
            n = (op == 4'd10) ? flag : rb();
            push(nm, 1'b1, 16'($urandom), rb(), z, n, 1'b1,
                 ex(3'd2, aop, sb, (br && flag) ? S_PCL : 9'h000));
            if (is_mem) begin
                for (int i = 0; i <= mw; i++)
                    push(nm, 1'b1, 16'($urandom), (i == mw), rb(), rb(), 1'b1,
                         ex(3'd3, 4'd0, 2'd1, S_REQ | ((op == 4'd8) ? S_WE : 9'h000)));
            end
            if (wb)
                push(nm, 1'b1, 16'($urandom), rb(), rb(), rb(), 1'b1,
                     ex(3'd4, aop, sb, S_RWE | ((op == 4'd7) ? S_WBS : 9'h000)));
        end
    endtask

    // k cycles in a terminal state, then reset back to FETCH.
    task automatic terminal(input logic [63:0] nm, input logic [2:0] st, input logic [8:0] stb,
                            input int k);
        for (int i = 0; i < k; i++)
            push(nm, 1'b1, 16'($urandom), rb(), rb(), rb(), 1'b1, ex(st, 4'd0, 2'd0, stb));
        push(nm, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, ex(3'd0, 4'd0, 2'd0, 9'h000));
        push(nm, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, ex(3'd0, 4'd0, 2'd0, 9'h000));
    endtask

    // Watchdog: flags a run that does not finish within the allowed time.
    initial begin
        #1000000;
        if (!done_r) begin
            n_fail++;
            $display("FAIL timeout: record stream did not complete in time");
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end else begin
            n_tests = n_tests;
        end
    end

    initial begin
        logic [17:0] act;
        logic [3:0]  op;

        // ADD r1 = r2 + r3 with memory always ready: FETCH, DECODE, EXEC, WB.
        add_tab[0] = mk("add", 1'b1, 16'h0298, 1'b1, 1'b0, 1'b0, 1'b1, ex(3'd0, 4'd0, 2'd0, S_IR | S_PCI | S_REQ));
        add_tab[1] = mk("add", 1'b1, 16'h0298, 1'b1, 1'b0, 1'b0, 1'b1, ex(3'd1, 4'd0, 2'd0, 9'h000));
        add_tab[2] = mk("add", 1'b1, 16'h0298, 1'b1, 1'b0, 1'b0, 1'b1, ex(3'd2, 4'd0, 2'd0, 9'h000));
        add_tab[3] = mk("add", 1'b1, 16'h0298, 1'b1, 1'b0, 1'b0, 1'b1, ex(3'd4, 4'd0, 2'd0, S_RWE));

        // Reset held two cycles, then first released cycle must request memory.
        push("reset", 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, ex(3'd0, 4'd0, 2'd0, 9'h000));
        push("reset", 1'b0, 16'hB000, 1'b1, 1'b0, 1'b1, 1'b1, ex(3'd0, 4'd0, 2'd0, 9'h000));
        push("rel", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, ex(3'd0, 4'd0, 2'd0, S_REQ));
        for (int i = 0; i < 4; i++) q.push_back(add_tab[i]);

        gen("lw", 16'h7283, 0, 2, 1'b0);
        gen("beq_t", 16'h9050, 0, 0, 1'b1);
        gen("beq_nt", 16'h9050, 0, 0, 1'b0);
        gen("blt_t", 16'hA050, 1, 0, 1'b1);
        gen("blt_nt", 16'hA050, 0, 0, 1'b0);
        gen("jmp", 16'hB123, 0, 0, 1'b0);
        gen("sw", 16'h8283, 1, 1, 1'b0);

        // SW with reset landing in the MEM wait: bus drops that cycle, FETCH next.
        push("sw_rst", 1'b1, 16'h8283, 1'b1, 1'b0, 1'b0, 1'b1, ex(3'd0, 4'd0, 2'd0, S_IR | S_PCI | S_REQ));
        push("sw_rst", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, ex(3'd1, 4'd0, 2'd0, 9'h000));
        push("sw_rst", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, ex(3'd2, 4'd0, 2'd1, 9'h000));
        push("sw_rst", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, ex(3'd3, 4'd0, 2'd1, S_REQ | S_WE));
        push("sw_rst", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, ex(3'd3, 4'd0, 2'd1, 9'h000));
        push("sw_rst", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, ex(3'd0, 4'd0, 2'd0, S_REQ));

        // Random legal instruction stream with random wait states and flags.
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 11));
            gen("rand", {op, 12'($urandom)}, $urandom_range(0, 2), $urandom_range(0, 2), rb());
        end

        gen("illegal", 16'hC000, 0, 0, 1'b0);
        terminal("illegal", 3'd6, S_TRP, 4);
        gen("halt", 16'hF000, 1, 0, 1'b0);
        terminal("halt", 3'd5, S_HLT, 4);
        gen("after", 16'h5abc, 0, 0, 1'b0);
        gen("after", 16'h6abc, 2, 0, 1'b0);

        // Apply records: drive just after the rising edge, check on the falling edge.
        rst_n = 1'b0;
        bus.instr = 16'h0000;
        bus.mem_ready = 1'b0;
        bus.zero = 1'b0;
        bus.neg = 1'b0;
        @(posedge clk);
        #1;
        act = {bus.state, bus.alu_op, bus.alu_src_b, bus.ir_we, bus.pc_inc,
               bus.pc_load, bus.reg_we, bus.wb_sel, bus.mem_req, bus.mem_we,
               bus.halted, bus.trap};
        n_tests++;
        if (act !== 18'h00000) begin
            n_fail++;
            $display("FAIL reset state: got state=%0d alu_op=%0d src_b=%0d strobes=%09b, expected all zero",
                     act[17:15], act[14:11], act[10:9], act[8:0]);
        end
        for (int i = 0; i < q.size(); i++) begin
            rst_n         = q[i].rst;
            bus.instr     = q[i].ins;
            bus.mem_ready = q[i].rdy;
            bus.zero      = q[i].z;
            bus.neg       = q[i].n;
            @(negedge clk);
            if (q[i].chk) begin
                act = {bus.state, bus.alu_op, bus.alu_src_b, bus.ir_we, bus.pc_inc,
                       bus.pc_load, bus.reg_we, bus.wb_sel, bus.mem_req, bus.mem_we,
                       bus.halted, bus.trap};
                n_tests++;
                if (act !== q[i].exp) begin
                    n_fail++;
                    $display("FAIL %0s cycle %0d: got state=%0d alu_op=%0d src_b=%0d strobes=%09b, expected state=%0d alu_op=%0d src_b=%0d strobes=%09b",
                             q[i].nm, i, act[17:15], act[14:11], act[10:9], act[8:0],
                             q[i].exp[17:15], q[i].exp[14:11], q[i].exp[10:9], q[i].exp[8:0]);
                end
            end
            @(posedge clk);
            #1;
        end
        done_r = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
